// File: rtl/mips_pkg.sv
// Shared encodings, ALU op enum and pipeline-register layouts for the mips_cpu core.
package mips_pkg;

  localparam int XLEN      = 32;
  localparam int PC_W      = 10;
  localparam int REG_AW    = 5;
  localparam int ROM_DEPTH = 1024;

  localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0000;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_MUL = 6'h18;
  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_SLT = 6'h2A;

  typedef enum logic [3:0] {
    ALU_ADD = 4'd0,
    ALU_SUB = 4'd1,
    ALU_AND = 4'd2,
    ALU_OR  = 4'd3,
    ALU_SLT = 4'd4,
    ALU_MUL = 4'd5
  } alu_op_e;

  typedef struct packed {
    logic [XLEN-1:0] instr;
    logic [PC_W-1:0] pc;
  } if_id_t;

  typedef struct packed {
    alu_op_e           alu_op;
    logic [XLEN-1:0]   a;
    logic [XLEN-1:0]   b;
    logic [XLEN-1:0]   st_data;
    logic [REG_AW-1:0] dest;
    logic              we;
    logic              mem_rd;
    logic              mem_wr;
  } id_ex_t;

  typedef struct packed {
    logic [XLEN-1:0]   result;
    logic [XLEN-1:0]   st_data;
    logic [REG_AW-1:0] dest;
    logic              we;
    logic              mem_rd;
    logic              mem_wr;
  } ex_mem_t;

  typedef struct packed {
    logic [XLEN-1:0]   result;
    logic [REG_AW-1:0] dest;
    logic              we;
  } mem_wb_t;

  function automatic logic [XLEN-1:0] sext16(input logic [15:0] imm);
    return {{16{imm[15]}}, imm};
  endfunction

endpackage

// File: rtl/mips_alu.sv
// Combinational ALU for mips_cpu. Multiply exists only when MIPS_MUL_EN is defined.
module mips_alu
  import mips_pkg::*;
(
  input  alu_op_e         op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic [XLEN-1:0] y
);

  always_comb begin
    y = '0;
    case (op)
      ALU_ADD: y = a + b;
      ALU_SUB: y = a - b;
      ALU_AND: y = a & b;
      ALU_OR:  y = a | b;
      ALU_SLT: y = {{(XLEN-1){1'b0}}, $signed(a) < $signed(b)};
`ifdef MIPS_MUL_EN
      ALU_MUL: y = a * b;
`endif
      default: y = '0;
    endcase
  end

endmodule

// File: rtl/mips_cpu.sv
// 5-stage MIPS-subset core, no forwarding/interlocks, one branch delay slot.
// Optional multiply is enabled by defining MIPS_MUL_EN.
module mips_cpu
  import mips_pkg::*;
#(
  parameter string           PROG_FILE = "program.hex",
  parameter logic [PC_W-1:0] PC_RESET  = 10'd0
) (
  input  logic            CLK,
  input  logic            Rst,
  input  logic [XLEN-1:0] Data_BUS_READ,
  output logic [XLEN-1:0] ADDR,
  output logic [XLEN-1:0] Data_BUS_WRITE,
  output logic            CS,
  output logic            WR_RD
);

  logic            CLK_SYS;
  logic [PC_W-1:0] PcPointer;

  logic [XLEN-1:0] rom_mem [ROM_DEPTH];
  logic [XLEN-1:0] rf_q [32];

  logic [PC_W-1:0] pc_q, pc_d;
  if_id_t          if_id_q, if_id_d;
  id_ex_t          id_ex_q, id_ex_d;
  ex_mem_t         ex_mem_q, ex_mem_d;
  mem_wb_t         mem_wb_q, mem_wb_d;

  logic [5:0]        opcode, funct;
  logic [REG_AW-1:0] rs_a, rt_a, rd_a;
  logic [XLEN-1:0]   imm_ext, rs_val, rt_val, alu_y;
  logic              branch_taken;
  logic [PC_W-1:0]   branch_target;

  assign CLK_SYS   = CLK;
  assign PcPointer = pc_q;

  // IF
  always_comb begin
    if_id_d = '{instr: rom_mem[pc_q], pc: pc_q};
    pc_d    = branch_taken ? branch_target : pc_q + 10'd1;
  end

  // ID: register read is write-through against the instruction in WB
  always_comb begin
    opcode  = if_id_q.instr[31:26];
    rs_a    = if_id_q.instr[25:21];
    rt_a    = if_id_q.instr[20:16];
    rd_a    = if_id_q.instr[15:11];
    funct   = if_id_q.instr[5:0];
    imm_ext = sext16(if_id_q.instr[15:0]);

    rs_val = (rs_a == '0) ? '0 : rf_q[rs_a];
    if (mem_wb_q.we && mem_wb_q.dest == rs_a) rs_val = mem_wb_q.result;
    rt_val = (rt_a == '0) ? '0 : rf_q[rt_a];
    if (mem_wb_q.we && mem_wb_q.dest == rt_a) rt_val = mem_wb_q.result;

    id_ex_d       = '0;
    branch_taken  = 1'b0;
    branch_target = '0;

    case (opcode)
      OP_RTYPE: begin
        id_ex_d.a    = rs_val;
        id_ex_d.b    = rt_val;
        id_ex_d.dest = rd_a;
        case (funct)
          FN_ADD: begin id_ex_d.alu_op = ALU_ADD; id_ex_d.we = 1'b1; end
          FN_SUB: begin id_ex_d.alu_op = ALU_SUB; id_ex_d.we = 1'b1; end
          FN_AND: begin id_ex_d.alu_op = ALU_AND; id_ex_d.we = 1'b1; end
          FN_OR:  begin id_ex_d.alu_op = ALU_OR;  id_ex_d.we = 1'b1; end
          FN_SLT: begin id_ex_d.alu_op = ALU_SLT; id_ex_d.we = 1'b1; end
          FN_MUL: begin
`ifdef MIPS_MUL_EN
            id_ex_d.alu_op = ALU_MUL;
            id_ex_d.we     = 1'b1;
`endif
          end
          default: ;
        endcase
      end
      OP_ADDI, OP_LW: begin
        id_ex_d.alu_op = ALU_ADD;
        id_ex_d.a      = rs_val;
        id_ex_d.b      = imm_ext;
        id_ex_d.dest   = rt_a;
        id_ex_d.we     = 1'b1;
        id_ex_d.mem_rd = (opcode == OP_LW);
      end
      OP_SW: begin
        id_ex_d.alu_op  = ALU_ADD;
        id_ex_d.a       = rs_val;
        id_ex_d.b       = imm_ext;
        id_ex_d.st_data = rt_val;
        id_ex_d.mem_wr  = 1'b1;
      end
      OP_BEQ: begin
        branch_taken  = (rs_val == rt_val);
        branch_target = if_id_q.pc + 10'd1 + imm_ext[PC_W-1:0];
      end
      OP_J: begin
        branch_taken  = 1'b1;
        branch_target = if_id_q.instr[PC_W-1:0];
      end
      default: ;
    endcase

    // r0 is hard-wired, so any write to it is dropped at decode.
    if (id_ex_d.dest == '0) id_ex_d.we = 1'b0;
  end

  mips_alu u_alu (
    .op (id_ex_q.alu_op),
    .a  (id_ex_q.a),
    .b  (id_ex_q.b),
    .y  (alu_y)
  );

  // EX and MEM
  always_comb begin
    ex_mem_d = '{result: alu_y, st_data: id_ex_q.st_data, dest: id_ex_q.dest,
                 we: id_ex_q.we, mem_rd: id_ex_q.mem_rd, mem_wr: id_ex_q.mem_wr};
    mem_wb_d = '{result: ex_mem_q.mem_rd ? Data_BUS_READ : ex_mem_q.result,
                 dest: ex_mem_q.dest, we: ex_mem_q.we};
  end

  assign CS             = ex_mem_q.mem_rd | ex_mem_q.mem_wr;
  assign WR_RD          = ex_mem_q.mem_wr;
  assign ADDR           = CS ? ex_mem_q.result : '0;
  assign Data_BUS_WRITE = ex_mem_q.mem_wr ? ex_mem_q.st_data : '0;

  always_ff @(posedge CLK_SYS or negedge Rst) begin
    if (!Rst) begin
      pc_q     <= PC_RESET;
      if_id_q  <= '{instr: NOP_INSTR, pc: '0};
      id_ex_q  <= '0;
      ex_mem_q <= '0;
      mem_wb_q <= '0;
    end else begin
      pc_q     <= pc_d;
      if_id_q  <= if_id_d;
      id_ex_q  <= id_ex_d;
      ex_mem_q <= ex_mem_d;
      mem_wb_q <= mem_wb_d;
    end
  end

  // WB
  always_ff @(posedge CLK_SYS or negedge Rst) begin
    if (!Rst) begin
      for (int i = 0; i < 32; i++) rf_q[i] <= '0;
    end else if (mem_wb_q.we) begin
      rf_q[mem_wb_q.dest] <= mem_wb_q.result;
    end
  end

endmodule

// File: tb/tb_mips_cpu.sv
// Directed program bench for mips_cpu: bus-transaction scoreboard plus fetch-order PC trace.
module tb_mips_cpu;

  logic        clk;
  logic        rst_n;
  logic [31:0] data_bus_read;
  logic [31:0] addr;
  logic [31:0] data_bus_write;
  logic        cs;
  logic        wr_rd;

  int tests_run    = 0;
  int tests_failed = 0;

  // {is_write, addr, data}
  logic [64:0] exp_q[$];
  logic [9:0]  pc_trace[$];

  mips_cpu #(
    .PROG_FILE (""),
    .PC_RESET  (10'd0)
  ) dut (
    .CLK            (clk),
    .Rst            (rst_n),
    .Data_BUS_READ  (data_bus_read),
    .ADDR           (addr),
    .Data_BUS_WRITE (data_bus_write),
    .CS             (cs),
    .WR_RD          (wr_rd)
  );

  // clock / reset
  initial clk = 1'b0;
  always #50 clk = ~clk;

  // Bus slave: returns the load pattern only while a read is actually on the bus.
  assign data_bus_read = (cs && !wr_rd) ? 32'h0000_1DAA : 32'hBAD0_BAD0;

  task automatic check_eq(input string tag, input logic [95:0] got, input logic [95:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] rs,
                                        input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  function automatic logic [31:0] enc_r(input logic [4:0] rs, input logic [4:0] rt,
                                        input logic [4:0] rd, input logic [5:0] fn);
    return {6'h00, rs, rt, rd, 5'd0, fn};
  endfunction

  task automatic load_program();
    for (int i = 0; i < 1024; i++) dut.rom_mem[i] = 32'h0;
    dut.rom_mem[0]  = enc_i(6'h08, 5'd0, 5'd1, 16'd5);       // addi r1,r0,5
    dut.rom_mem[3]  = enc_i(6'h08, 5'd1, 5'd2, 16'd3);       // addi r2,r1,3
    dut.rom_mem[6]  = enc_i(6'h2B, 5'd0, 5'd2, 16'h0010);    // sw r2,16(r0)
    dut.rom_mem[7]  = enc_i(6'h23, 5'd0, 5'd3, 16'h0004);    // lw r3,4(r0)
    dut.rom_mem[10] = enc_i(6'h04, 5'd0, 5'd0, 16'd4);       // beq r0,r0,+4
    dut.rom_mem[11] = enc_i(6'h2B, 5'd0, 5'd3, 16'h0008);    // sw r3,8(r0)
    for (int i = 12; i <= 14; i++)
      dut.rom_mem[i] = enc_i(6'h2B, 5'd0, 5'd1, 16'h0100);   // skipped marker
    dut.rom_mem[15] = enc_i(6'h04, 5'd1, 5'd0, 16'd4);       // beq r1,r0,+4 (not taken)
    dut.rom_mem[16] = enc_i(6'h2B, 5'd0, 5'd1, 16'h0020);    // sw r1,0x20(r0)
    dut.rom_mem[17] = enc_i(6'h2B, 5'd0, 5'd2, 16'h0024);    // sw r2,0x24(r0)
    dut.rom_mem[18] = enc_i(6'h08, 5'd0, 5'd4, 16'd7);       // addi r4,r0,7
    dut.rom_mem[19] = enc_i(6'h08, 5'd0, 5'd5, 16'd6);       // addi r5,r0,6
    dut.rom_mem[20] = enc_r(5'd4, 5'd4, 5'd4, 6'h3F);        // unknown funct -> nop
    dut.rom_mem[21] = enc_i(6'h3F, 5'd0, 5'd5, 16'd1);       // unknown opcode -> nop
    dut.rom_mem[22] = enc_r(5'd4, 5'd5, 5'd6, 6'h18);        // mul r6,r4,r5
    dut.rom_mem[25] = enc_i(6'h2B, 5'd0, 5'd6, 16'h0000);    // sw r6,0(r0)
    dut.rom_mem[26] = enc_i(6'h08, 5'd0, 5'd0, 16'd9);       // addi r0,r0,9
    dut.rom_mem[29] = enc_i(6'h2B, 5'd0, 5'd0, 16'h0030);    // sw r0,0x30(r0)
    dut.rom_mem[30] = enc_r(5'd4, 5'd5, 5'd7, 6'h22);        // sub r7,r4,r5
    dut.rom_mem[31] = enc_r(5'd4, 5'd5, 5'd8, 6'h24);        // and r8,r4,r5
    dut.rom_mem[32] = enc_r(5'd4, 5'd5, 5'd9, 6'h25);        // or  r9,r4,r5
    dut.rom_mem[33] = enc_r(5'd5, 5'd4, 5'd10, 6'h2A);       // slt r10,r5,r4
    dut.rom_mem[34] = enc_i(6'h08, 5'd0, 5'd11, 16'hFFFF);   // addi r11,r0,-1
    dut.rom_mem[37] = enc_r(5'd11, 5'd0, 5'd12, 6'h2A);      // slt r12,r11,r0
    dut.rom_mem[38] = enc_i(6'h2B, 5'd0, 5'd7, 16'h0040);
    dut.rom_mem[39] = enc_i(6'h2B, 5'd0, 5'd8, 16'h0044);
    dut.rom_mem[40] = enc_i(6'h2B, 5'd0, 5'd9, 16'h0048);
    dut.rom_mem[41] = enc_i(6'h2B, 5'd0, 5'd10, 16'h004C);
    dut.rom_mem[42] = enc_i(6'h2B, 5'd0, 5'd12, 16'h0050);
    dut.rom_mem[43] = enc_r(5'd11, 5'd11, 5'd13, 6'h20);     // add r13,r11,r11
    dut.rom_mem[46] = enc_i(6'h2B, 5'd4, 5'd13, 16'hFFFC);   // sw r13,-4(r4)
    dut.rom_mem[47] = {6'h02, 26'd1023};                     // j 1023
    dut.rom_mem[48] = enc_i(6'h2B, 5'd0, 5'd1, 16'h0060);    // delay slot
    dut.rom_mem[49] = enc_i(6'h2B, 5'd0, 5'd1, 16'h0100);    // skipped marker
    dut.rom_mem[1023] = {6'h02, 26'd0};                      // j 0
  endtask

  task automatic build_expectations();
    logic [31:0] mul_res;
`ifdef MIPS_MUL_EN
    mul_res = 32'd42;
`else
    mul_res = 32'd0;
`endif
    exp_q.push_back({1'b1, 32'h10, 32'h8});
    exp_q.push_back({1'b0, 32'h4,  32'h0});
    exp_q.push_back({1'b1, 32'h8,  32'h1DAA});
    exp_q.push_back({1'b1, 32'h20, 32'd5});
    exp_q.push_back({1'b1, 32'h24, 32'd8});
    exp_q.push_back({1'b1, 32'h0,  mul_res});
    exp_q.push_back({1'b1, 32'h30, 32'd0});
    exp_q.push_back({1'b1, 32'h40, 32'd1});
    exp_q.push_back({1'b1, 32'h44, 32'd6});
    exp_q.push_back({1'b1, 32'h48, 32'd7});
    exp_q.push_back({1'b1, 32'h4C, 32'd1});
    exp_q.push_back({1'b1, 32'h50, 32'd1});
    exp_q.push_back({1'b1, 32'h3,  32'hFFFF_FFFE});
    exp_q.push_back({1'b1, 32'h60, 32'd5});

    for (int i = 0; i <= 11; i++) pc_trace.push_back(10'(i));
    for (int i = 15; i <= 48; i++) pc_trace.push_back(10'(i));
    pc_trace.push_back(10'd1023);
    pc_trace.push_back(10'd0);
    pc_trace.push_back(10'd0);
    pc_trace.push_back(10'd1);
    pc_trace.push_back(10'd2);
  endtask

  // scoreboard: called once per cycle at the falling edge
  task automatic sample_bus();
    logic [64:0] e;
    if (cs) begin
      if (exp_q.size() == 0) begin
        check_eq("bus_extra_cs", 96'(cs), 96'd0);
      end else begin
        e = exp_q.pop_front();
        check_eq("bus_wr_rd", 96'(wr_rd), 96'(e[64]));
        check_eq("bus_addr", 96'(addr), 96'(e[63:32]));
        if (e[64]) check_eq("bus_wdata", 96'(data_bus_write), 96'(e[31:0]));
      end
    end else begin
      check_eq("bus_idle", 96'({wr_rd, addr, data_bus_write}), 96'd0);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    load_program();
    build_expectations();

    // in reset: PC held at PC_RESET, bus quiet
    @(negedge clk);
    check_eq("pc_in_reset", 96'(dut.PcPointer), 96'(pc_trace[0]));
    sample_bus();
    @(negedge clk);
    check_eq("pc_in_reset2", 96'(dut.PcPointer), 96'(pc_trace[0]));
    sample_bus();
    rst_n = 1'b1;

    for (int k = 1; k < pc_trace.size(); k++) begin
      @(negedge clk);
      check_eq($sformatf("pc_trace[%0d]", k), 96'(dut.PcPointer), 96'(pc_trace[k]));
      sample_bus();
    end
    check_eq("bus_pending", 96'(exp_q.size()), 96'd0);

    // restart and abort with a store on the bus
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 1; k <= 9; k++) @(negedge clk);
    check_eq("abort_pre_cs", 96'({cs, wr_rd, addr}), 96'({1'b1, 1'b1, 32'h10}));
    #10;
    rst_n = 1'b0;
    #1;
    check_eq("abort_bus", 96'({cs, wr_rd, addr, data_bus_write}), 96'd0);
    check_eq("abort_pc", 96'(dut.PcPointer), 96'd0);
    @(negedge clk);
    check_eq("abort_hold", 96'({cs, dut.PcPointer}), 96'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
